branch_rs: RTL
==============

# branch_rs

Reservation station for the branch unit in the out-of-order core. Holds dispatched conditional-jump instructions (jz/jnz/jgt/jlt) until their target and compare operands are available, snoops the common data bus (CDB) to capture results, and issues the oldest ready branch each cycle. Issued branches go straight into the combinational branch resolver, which always accepts them.

## Interface
Parameters:
- DEPTH, 4, number of entries (≥2)
- XLEN, 16, operand/data width
- TAG_W, 4, ROB index / operand tag width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  misprediction flush; invalidates all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_opcode  in  4  branch opcode
- disp_rob  in  TAG_W  ROB index of the branch
- disp_imm  in  9  immediate field, carried unchanged
- disp_{t,a,b}_rdy  in  1 each  operand already valid
- disp_{t,a,b}_tag  in  TAG_W each  producer ROB tag when not ready
- disp_{t,a,b}_val  in  XLEN each  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing ROB tag
- cdb_value  in  XLEN  broadcast result
- iss_valid  out  1  issuing an entry this cycle
- iss_opcode  out  4; iss_rob  out  TAG_W; iss_imm  out  9
- iss_vt, iss_va, iss_vb  out  XLEN  operand values
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entries are kept age-ordered: slot 0 is the oldest. Removal compacts younger entries downward in the same edge. Dispatch writes to slot count (after compaction).
- Entry contents: valid, opcode, rob, imm, and three operand fields (rdy, tag, val).
- Wakeup: on cdb_valid, every valid entry whose operand has rdy=0 and tag==cdb_tag sets rdy=1 and val=cdb_value.
- Dispatch capture: if a dispatched operand has rdy=0 and its tag matches a same-cycle CDB broadcast, it is stored with rdy=1 and val=cdb_value.
- Select: the lowest slot with valid and all three rdy set is issued. iss_* is combinational from that slot. That entry is removed at the next edge. At most one issue per cycle.
- disp_ready = (count < DEPTH), computed from registered count only. A full station does not accept dispatch in the same cycle it issues.
- Dispatch fires on disp_valid && disp_ready.
- Opcodes outside 1000–1011 are still stored and issued. Filtering them is the branch unit's job.
- flush: at the edge, all entries are invalidated and count becomes 0. Flush takes priority over a same-cycle dispatch, issue, or wakeup. iss_valid still reflects pre-flush state during the flush cycle.
- Reset: all entries invalid, count=0, disp_ready=1, iss_valid=0, all iss_* data outputs 0.

## Timing
- Dispatch in cycle N with all operands ready → iss_valid in N+1 at the earliest (default build).
- CDB wakeup in cycle N → entry may issue in N+1. There is no CDB-to-issue bypass.
- Issue in N and dispatch in N together: count(N+1) = count(N).
- Reset asserted mid-operation clears state immediately, regardless of clock.
- Tag match compares all TAG_W bits. Operand values are stored unchanged at XLEN.

## Configuration
- BRANCH_RS_FAST_ISSUE_EN defined:
  - When the station has no ready entry and the dispatched instruction has all three operands ready (including via dispatch capture), it issues combinationally in the same cycle.
  - That instruction is not written into any slot.
  - This path is suppressed during flush.
- Not defined: no bypass. Minimum dispatch-to-issue latency is one cycle.

## Test plan
- Reset, then dispatch jz rob=3, t=0x0040, a=0 (all rdy) in cycle 1 → iss_valid=1 in cycle 2 with iss_rob=3, iss_vt=0x0040, iss_va=0; count returns to 0 in cycle 3.
- Dispatch jgt rob=5 with a waiting on tag 2, then jlt rob=6 all ready; CDB tag=2 value=7 in cycle 3 → rob=6 issues first; rob=5 issues cycle 4 with iss_va=7.
- Fill DEPTH=4 entries, all waiting → disp_ready=0 and count=4. Broadcast the slot-1 tag → slot 1 issues, the rest compact, and disp_ready=1 the following cycle.
- Dispatch with a_rdy=0, a_tag=9 while the CDB broadcasts tag 9 value 0x1234 in the same cycle → entry stored ready and issues next cycle with iss_va=0x1234.
- Three entries valid, assert flush together with disp_valid → count=0 and no entry issues afterward.
- With BRANCH_RS_FAST_ISSUE_EN, dispatch jnz all-ready into an empty station → iss_valid=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/branch_rs.sv
// Age-ordered reservation station for the branch unit with CDB wakeup and oldest-ready issue.
// Optional same-cycle dispatch-to-issue bypass: define BRANCH_RS_FAST_ISSUE_EN.
module branch_rs #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 16,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_opcode,
    input  logic [TAG_W-1:0]           disp_rob,
    input  logic [8:0]                 disp_imm,
    input  logic                       disp_t_rdy,
    input  logic [TAG_W-1:0]           disp_t_tag,
    input  logic [XLEN-1:0]            disp_t_val,
    input  logic                       disp_a_rdy,
    input  logic [TAG_W-1:0]           disp_a_tag,
    input  logic [XLEN-1:0]            disp_a_val,
    input  logic                       disp_b_rdy,
    input  logic [TAG_W-1:0]           disp_b_tag,
    input  logic [XLEN-1:0]            disp_b_val,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_value,
    output logic                       iss_valid,
    output logic [3:0]                 iss_opcode,
    output logic [TAG_W-1:0]           iss_rob,
    output logic [8:0]                 iss_imm,
    output logic [XLEN-1:0]            iss_vt,
    output logic [XLEN-1:0]            iss_va,
    output logic [XLEN-1:0]            iss_vb,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } operand_t;

    typedef struct packed {
        logic             valid;
        logic [3:0]       opcode;
        logic [TAG_W-1:0] rob;
        logic [8:0]       imm;
        operand_t         t;
        operand_t         a;
        operand_t         b;
    } entry_t;

    entry_t        slots_q   [DEPTH];
    entry_t        woken     [DEPTH];
    entry_t        shifted   [DEPTH];
    entry_t        slots_d   [DEPTH];
    entry_t        disp_entry;
    entry_t        issue_entry;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic          fast_issue;
    logic          disp_fire;

    function automatic operand_t snoop(input operand_t op, input logic cv,
                                       input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cval);
        operand_t r;
        r = op;
        if (cv && !op.rdy && (op.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cval;
        end
        return r;
    endfunction

    assign count      = count_q;
    assign disp_ready = (count_q < CW'(DEPTH));

    // Dispatched operands can be captured from a CDB broadcast in the same cycle.
    always_comb begin
        disp_entry        = '0;
        disp_entry.valid  = 1'b1;
        disp_entry.opcode = disp_opcode;
        disp_entry.rob    = disp_rob;
        disp_entry.imm    = disp_imm;
        disp_entry.t = snoop('{disp_t_rdy, disp_t_tag, disp_t_val}, cdb_valid, cdb_tag, cdb_value);
        disp_entry.a = snoop('{disp_a_rdy, disp_a_tag, disp_a_val}, cdb_valid, cdb_tag, cdb_value);
        disp_entry.b = snoop('{disp_b_rdy, disp_b_tag, disp_b_val}, cdb_valid, cdb_tag, cdb_value);
    end

    // Select only looks at registered readiness, so a wakeup never issues in its own cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots_q[i].valid && slots_q[i].t.rdy && slots_q[i].a.rdy && slots_q[i].b.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

`ifdef BRANCH_RS_FAST_ISSUE_EN
    assign fast_issue = disp_valid && disp_ready && !sel_found && !flush &&
                        disp_entry.t.rdy && disp_entry.a.rdy && disp_entry.b.rdy;
`else
    assign fast_issue = 1'b0;
`endif

    assign disp_fire = disp_valid && disp_ready && !fast_issue;

    always_comb begin
        issue_entry = '0;
        if (sel_found) begin
            issue_entry = slots_q[sel_idx];
        end else if (fast_issue) begin
            issue_entry = disp_entry;
        end
    end

    assign iss_valid  = sel_found || fast_issue;
    assign iss_opcode = issue_entry.opcode;
    assign iss_rob    = issue_entry.rob;
    assign iss_imm    = issue_entry.imm;
    assign iss_vt     = issue_entry.t.val;
    assign iss_va     = issue_entry.a.val;
    assign iss_vb     = issue_entry.b.val;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = slots_q[i];
            if (slots_q[i].valid) begin
                woken[i].t = snoop(slots_q[i].t, cdb_valid, cdb_tag, cdb_value);
                woken[i].a = snoop(slots_q[i].a, cdb_valid, cdb_tag, cdb_value);
                woken[i].b = snoop(slots_q[i].b, cdb_valid, cdb_tag, cdb_value);
            end
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = woken[i + 1];
        end
        shifted[DEPTH-1] = '0;
    end

    // Compaction first, then dispatch lands at the first free slot after compaction.
    always_comb begin
        wr_idx  = count_q - CW'(sel_found);
        count_d = wr_idx + CW'(disp_fire);
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = (sel_found && (IW'(i) >= sel_idx)) ? shifted[i] : woken[i];
            if (disp_fire && (CW'(i) == wr_idx)) begin
                slots_d[i] = disp_entry;
            end
        end
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i] = '0;
            end
        end
    end

    // NOTE: the slot array is reset along with the control state so that idle iss_* data
    // reads as zero and no stale tag can ever match a broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

endmodule
